// File: rtl/bus_uart_tx.sv
// bus_uart_tx: memory-mapped 8N1 UART transmitter with TX FIFO and programmable bit divisor
module bus_uart_tx #(
  parameter logic [29:0] BASE        = 30'h0,
  parameter int          DEPTH       = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [29:0] bus_addr,
  input  logic [31:0] bus_data_w,
  input  logic [3:0]  bus_mask_w,
  output logic [31:0] bus_data_r,
  output logic        uart_tx
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state_q, state_d;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   div_q, div_d, baud_q, baud_d, lat_q, lat_d, div_m1;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          tx_q, tx_d;
  logic [31:0]   rd_q, rd_d, status;
  logic [1:0]    off;
  logic          sel, wr, push, push_ok, pop, tick;
  logic          unused_ok;
  assign unused_ok = ^bus_data_w[31:16];
  assign sel     = bus_addr[29:2] == BASE[29:2];
  assign off     = bus_addr[1:0];
  assign wr      = sel && |bus_mask_w;
  assign push    = wr && off == 2'd0 && bus_mask_w[0];
  assign tick    = baud_q == 16'd0;
  assign pop     = cnt_q != '0 && (state_q == IDLE || (state_q == STOP && tick));
  assign push_ok = push && (cnt_q != FULL || pop);
  assign div_m1  = (div_q == 16'd0) ? 16'd0 : div_q - 16'd1;
  assign status  = {20'b0, 4'(cnt_q), 4'b0, ovf_q, state_q != IDLE || cnt_q != '0, cnt_q == FULL, cnt_q == '0};
  // Transmit FSM: a pop starts a frame; each state holds for the latched divisor via the baud down-counter
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    lat_d   = lat_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    if (pop) begin
      state_d = START;
      baud_d  = div_m1;
      lat_d   = div_m1;
      sh_d    = mem_q[rp_q];
      tx_d    = 1'b0;
    end else if (!tick) begin
      baud_d = baud_q - 16'd1;
    end else begin
      case (state_q)
        START: begin
          state_d = DATA;
          baud_d  = lat_q;
          bit_d   = 3'd0;
          tx_d    = sh_q[0];
        end
        DATA: begin
          baud_d  = lat_q;
          state_d = (bit_q == 3'd7) ? STOP : DATA;
          bit_d   = (bit_q == 3'd7) ? bit_q : bit_q + 3'd1;
          sh_d    = sh_q >> 1;
          tx_d    = (bit_q == 3'd7) ? 1'b1 : sh_q[1];
        end
        STOP: begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
        default: ;
      endcase
    end
  end
  // Register-file side: FIFO pointers and count, sticky overflow, divisor lanes, registered read mux
  always_comb begin
    wp_d  = push_ok ? wp_q + AW'(1) : wp_q;
    rp_d  = pop ? rp_q + AW'(1) : rp_q;
    cnt_d = cnt_q + CW'(push_ok) - CW'(pop);
    ovf_d = (push && !push_ok) || (ovf_q && !(wr && off == 2'd1 && bus_mask_w[0] && bus_data_w[3]));
    div_d = {(wr && off == 2'd2 && bus_mask_w[1]) ? bus_data_w[15:8] : div_q[15:8],
             (wr && off == 2'd2 && bus_mask_w[0]) ? bus_data_w[7:0] : div_q[7:0]};
    rd_d  = !sel ? 32'h0 : (off == 2'd1) ? status : (off == 2'd2) ? {16'h0, div_q} : 32'h0;
  end
  // FIFO storage needs no reset: only entries behind the pointers are ever read
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wp_q] <= bus_data_w[7:0];
  end
  // State registers; reset aborts any frame and discards queued bytes
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      div_q   <= DEFAULT_DIV;
      baud_q  <= 16'd0;
      lat_q   <= 16'd0;
      bit_q   <= 3'd0;
      sh_q    <= 8'd0;
      tx_q    <= 1'b1;
      rd_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      div_q   <= div_d;
      baud_q  <= baud_d;
      lat_q   <= lat_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      rd_q    <= rd_d;
    end
  end
  assign bus_data_r = rd_q;
  assign uart_tx    = tx_q;
endmodule

// File: tb/tb_bus_uart_tx.sv
// tb_bus_uart_tx: randomized scoreboard bench with a frame-level reference model of the UART block
module tb_bus_uart_tx;
  localparam logic [29:0] BASE   = 30'h40;
  localparam int          DEPTH  = 8;
  localparam logic [29:0] A_DATA = BASE;
  localparam logic [29:0] A_STAT = BASE + 30'd1;
  localparam logic [29:0] A_DIV  = BASE + 30'd2;
  localparam logic [29:0] A_R3   = BASE + 30'd3;
  localparam logic [29:0] A_UN   = BASE + 30'd4;
  typedef struct {logic [7:0] b; int d; int start;} frame_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [29:0] addr;
  logic [31:0] wd;
  logic [3:0]  mask;
  logic [31:0] rd;
  logic        tx;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc_n = 0;
  logic [7:0]  mq[$];
  frame_t      eq[$];
  logic [31:0] rq[$];
  int          fl = 0;
  logic        m_ovf = 1'b0;
  logic [15:0] m_div = 16'd4;
  logic        ms;
  logic [1:0]  mo;
  int          md;
  logic [7:0]  mb;
  frame_t      fr;
  bit          act = 1'b0;
  frame_t      f;
  int          idx = 0;
  int          bad_at = -1;
  int          bp;
  logic        eb;
  logic [31:0] re;
  bit          found;
  int          r;

  bus_uart_tx #(.BASE(BASE), .DEPTH(DEPTH), .DEFAULT_DIV(16'd4)) dut (
    .clock(clk), .reset(rst), .bus_addr(addr), .bus_data_w(wd),
    .bus_mask_w(mask), .bus_data_r(rd), .uart_tx(tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic cyc(input logic [29:0] a, input logic [31:0] d, input logic [3:0] m);
    @(negedge clk);
    addr = a;
    wd   = d;
    mask = m;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(A_STAT, 32'h0, 4'h0);
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && (fl > 0 || mq.size() > 0 || act); i++) cyc(A_STAT, 32'h0, 4'h0);
    idle(3);
  endtask

  // Reference model: queue of waiting bytes plus remaining clocks of the frame on the line
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      mq.delete();
      eq.delete();
      rq.delete();
      fl    = 0;
      m_ovf = 1'b0;
      m_div = 16'd4;
    end else begin
      cyc_n++;
      ms = addr[29:2] == BASE[29:2];
      mo = addr[1:0];
      rq.push_back(!ms ? 32'h0 :
                   (mo == 2'd1) ? {20'h0, 4'(mq.size()), 4'h0, m_ovf, fl > 0 || mq.size() > 0,
                                   mq.size() == DEPTH, mq.size() == 0} :
                   (mo == 2'd2) ? {16'h0, m_div} : 32'h0);
      if (mq.size() > 0 && fl <= 1) begin
        md = (m_div == 16'd0) ? 1 : int'(m_div);
        mb = mq.pop_front();
        fr.b = mb;
        fr.d = md;
        fr.start = cyc_n;
        eq.push_back(fr);
        fl = 10 * md;
      end else if (fl > 0) begin
        fl--;
      end
      if (ms && mo == 2'd0 && mask[0]) begin
        if (mq.size() < DEPTH) mq.push_back(wd[7:0]);
        else m_ovf = 1'b1;
      end
      if (ms && mo == 2'd1 && mask[0] && wd[3]) m_ovf = 1'b0;
      if (ms && mo == 2'd2 && mask[0]) m_div[7:0] = wd[7:0];
      if (ms && mo == 2'd2 && mask[1]) m_div[15:8] = wd[15:8];
    end
  end

  // Monitor: checks every read response and decodes every serial frame against the scoreboard
  initial forever begin
    @(negedge clk);
    if (rst) begin
      act = 1'b0;
      chk("reset_tx", {31'b0, tx}, 32'h1);
      chk("reset_rd", rd, 32'h0);
    end else begin
      if (rq.size() > 0) begin
        re = rq.pop_front();
        chk("rd", rd, re);
      end
      if (!act && tx === 1'b0) begin
        if (eq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_start: line low at cycle %0d with no frame pending", cyc_n);
        end else begin
          f = eq.pop_front();
          act = 1'b1;
          idx = 0;
          bad_at = -1;
          chk("frame_start_cycle", cyc_n, f.start);
        end
      end
      if (act) begin
        bp = idx / f.d;
        eb = (bp == 0) ? 1'b0 : (bp == 9) ? 1'b1 : f.b[bp-1];
        if (tx !== eb && bad_at < 0) bad_at = idx;
        idx++;
        if (idx == 10 * f.d) begin
          act = 1'b0;
          n_cmp++;
          if (bad_at >= 0) begin
            n_bad++;
            $display("FAIL frame: byte %02h div %0d first wrong sample %0d of %0d", f.b, f.d, bad_at, 10 * f.d);
          end
        end
      end
    end
  end

  initial begin
    addr = A_UN;
    wd   = 32'h0;
    mask = 4'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cyc(A_STAT, 32'h0, 4'h0);
    cyc(A_UN, 32'h0, 4'h0);
    chk("status_empty", rd, 32'h1);
    cyc(A_DIV, 32'h0, 4'h0);
    chk("unselected", rd, 32'h0);
    cyc(A_R3, 32'h0, 4'h0);
    chk("div_reset", rd, 32'h4);
    cyc(A_R3, 32'hFFFF_FFFF, 4'hF);
    chk("offset3", rd, 32'h0);
    cyc(A_DATA, 32'hA5, 4'h1);
    idle(60);
    for (int i = 0; i < 10; i++) cyc(A_DATA, i, 4'h1);
    idle(420);
    chk("overflow_set", rd, 32'h9);
    cyc(A_STAT, 32'h8, 4'h1);
    idle(2);
    chk("overflow_clear", rd, 32'h1);
    cyc(A_DIV, 32'h0, 4'h3);
    cyc(A_DATA, 32'h3C, 4'h1);
    cyc(A_DATA, 32'hC3, 4'h1);
    idle(2);
    cyc(A_DIV, 32'h2, 4'h1);
    idle(60);
    cyc(A_DIV, 32'h4, 4'h1);
    for (int i = 0; i < 4; i++) cyc(A_DATA, $urandom, 4'h1);
    idle(14);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("reset_abort_tx", {31'b0, tx}, 32'h1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(2);
    chk("status_after_reset", rd, 32'h1);
    idle(100);
    for (int i = 0; i < 9; i++) cyc(A_DATA, 32'h50 + i, 4'h1);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (fl == 1 && mq.size() == DEPTH) begin
        addr = A_DATA; wd = 32'hEE; mask = 4'h1; found = 1'b1;
      end else begin
        addr = A_STAT; wd = 32'h0; mask = 4'h0;
      end
    end
    if (!found) begin
      n_cmp++;
      n_bad++;
      $display("FAIL coincide_bound: full FIFO at frame end not reached within 200 cycles");
    end
    cyc(A_STAT, 32'h0, 4'h0);
    cyc(A_STAT, 32'h0, 4'h0);
    chk("full_coincident_push", rd, 32'h806);
    drain();
    cyc(A_DIV, 32'h2, 4'h3);
    repeat (400) begin
      r = $urandom_range(0, 9);
      if (r < 4) cyc(A_DATA, $urandom, 4'($urandom_range(1, 15)));
      else if (r == 4) cyc(A_STAT, $urandom, 4'($urandom_range(1, 15)));
      else if (r == 5) cyc(A_DIV, 32'($urandom_range(0, 3)), 4'h1);
      else if (r == 6) cyc(A_R3, $urandom, 4'($urandom_range(0, 15)));
      else if (r == 7) cyc(A_UN + 30'($urandom_range(0, 3)), $urandom, 4'($urandom_range(0, 15)));
      else cyc(BASE + 30'($urandom_range(0, 3)), 32'h0, 4'h0);
    end
    drain();
    chk("frames_outstanding", eq.size(), 32'h0);
    chk("monitor_idle", {31'b0, act}, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
